// File: rtl/pipe_controller.sv
// pipe_controller: ID-stage decode, EX control register, hazard/forward unit
// and syscall halt FSM for a 5-stage MIPS-style pipeline.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   id_valid, op, funct,
//   rs, rt, rd                    instruction currently in ID
//   ex_branch_taken               branch in EX resolved taken (kills ID)
//   resume                        releases HALT
//   stall / flush                 hold PC+IF/ID / kill IF/ID (combinational)
//   ex_*                          registered EX control bundle
//   ex_fwd_a/b                    operand forward selects (01 EX/MEM, 10 MEM/WB)
//   halted                        core halted after a syscall drained
module pipe_controller #(
  parameter int REG_AW     = 5,
  parameter int ALUOP_W    = 4,
  parameter int FORWARD_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic [REG_AW-1:0]  rs,
  input  logic [REG_AW-1:0]  rt,
  input  logic [REG_AW-1:0]  rd,
  input  logic               ex_branch_taken,
  input  logic               resume,
  output logic               stall,
  output logic               flush,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_reg_we,
  output logic               ex_mem_we,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic               ex_shift,
  output logic               ex_shift_var,
  output logic               ex_usign,
  output logic               ex_load_imm,
  output logic               ex_store_half,
  output logic               ex_jal,
  output logic               ex_branch,
  output logic               ex_equ,
  output logic [REG_AW-1:0]  ex_wdst,
  output logic [1:0]         ex_fwd_a,
  output logic [1:0]         ex_fwd_b,
  output logic               halted
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
    OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c, OP_ORI = 6'h0d,
    OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SH = 6'h29, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
    F_SRAV = 6'h07, F_JR = 6'h08, F_SYSCALL = 6'h0c, F_ADDU = 6'h21, F_SUB = 6'h22,
    F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic reg_we, mem_we, mem_to_reg, alu_src, shift, shift_var;
    logic usign, load_imm, store_half, jal, branch, equ;
    logic [REG_AW-1:0] wdst;
  } ctrl_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  ctrl_t dec, ex_q;
  logic [3:0] alu4;
  logic is_r, is_jr, is_syscall, is_jump, uses_rs, uses_rt;
  logic rs_used, rt_used, ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use, raw, haz, issue;
  logic [1:0] fwd_a_d, fwd_b_d;
  state_t state;
  logic drain_cnt;
  logic ex_valid_q, mem_valid, mem_reg_we, mem_to_reg;
  logic [REG_AW-1:0] mem_wdst;

  // ---------------- decode ----------------
  always_comb begin
    dec        = '0;
    alu4       = 4'b0101;  // add is the default (add/addu/addi/addiu/lw/sw/j/jal/jr/syscall)
    is_r       = (op == OP_R);
    is_jr      = is_r && (funct == F_JR);
    is_syscall = is_r && (funct == F_SYSCALL);
    if (is_r) begin
      case (funct)
        F_SLL, F_SLLV: alu4 = 4'b0000;
        F_SRA, F_SRAV: alu4 = 4'b0001;
        F_SRL:         alu4 = 4'b0010;
        F_SUB:         alu4 = 4'b0110;
        F_AND:         alu4 = 4'b0111;
        F_OR:          alu4 = 4'b1000;
        F_NOR:         alu4 = 4'b1010;
        F_SLT:         alu4 = 4'b1011;
        F_SLTU:        alu4 = 4'b1100;
        default:       alu4 = 4'b0101;
      endcase
    end else begin
      case (op)
        OP_ANDI: alu4 = 4'b0111;
        OP_ORI:  alu4 = 4'b1000;
        OP_SLTI: alu4 = 4'b1011;
        default: alu4 = 4'b0101;
      endcase
    end
    dec.aluop      = ALUOP_W'(alu4);
    dec.reg_we     = !(op == OP_SW || op == OP_SH || op == OP_BEQ || op == OP_BNE ||
                       op == OP_J || is_jr || is_syscall);
    dec.mem_we     = (op == OP_SW) || (op == OP_SH);
    dec.mem_to_reg = (op == OP_LW);
    dec.store_half = (op == OP_SH);
    dec.branch     = (op == OP_BEQ) || (op == OP_BNE);
    dec.equ        = (op == OP_BEQ);
    dec.jal        = (op == OP_JAL);
    dec.load_imm   = (op == OP_LUI);
    dec.alu_src    = !is_r && !dec.branch && (op != OP_J) && (op != OP_JAL);
    dec.shift      = is_r && (funct == F_SLL || funct == F_SRL || funct == F_SRA ||
                              funct == F_SLLV || funct == F_SRAV);
    dec.shift_var  = is_r && (funct == F_SLLV || funct == F_SRAV);
    dec.usign      = (is_r && (funct == F_ADDU || funct == F_SLTU)) || (op == OP_ADDIU);
    dec.wdst       = is_r ? rd : (op == OP_JAL) ? REG_AW'(31) : rt;
    // Immediate shifts use shamt, not rs.
    uses_rs = !(op == OP_J || op == OP_JAL || op == OP_LUI || is_syscall ||
                (is_r && (funct == F_SLL || funct == F_SRL || funct == F_SRA)));
    uses_rt = is_r || dec.mem_we || dec.branch;
    is_jump = id_valid && (op == OP_J || op == OP_JAL || is_jr);
  end

  // ---------------- hazards / forwarding ----------------
  always_comb begin
    rs_used    = id_valid && uses_rs && (rs != '0);
    rt_used    = id_valid && uses_rt && (rt != '0);
    ex_hit_rs  = ex_valid_q && ex_q.reg_we && (ex_q.wdst == rs);
    ex_hit_rt  = ex_valid_q && ex_q.reg_we && (ex_q.wdst == rt);
    mem_hit_rs = mem_valid && mem_reg_we && (mem_wdst == rs);
    mem_hit_rt = mem_valid && mem_reg_we && (mem_wdst == rt);
    load_use   = ex_valid_q && ex_q.mem_to_reg &&
                 ((rs_used && ex_q.wdst == rs) || (rt_used && ex_q.wdst == rt));
    raw        = (rs_used && (ex_hit_rs || mem_hit_rs)) || (rt_used && (ex_hit_rt || mem_hit_rt));
    haz        = (FORWARD_EN != 0) ? load_use : raw;
    // A taken branch kills ID, so nothing in ID can be worth waiting for.
    stall      = !ex_branch_taken && (haz || state != RUN);
    // A stalled jump stays in IF/ID; flushing would kill the jump itself.
    flush      = ex_branch_taken || (is_jump && !stall);
    issue      = id_valid && !stall && !ex_branch_taken;
    fwd_a_d    = 2'b00;
    fwd_b_d    = 2'b00;
    if (FORWARD_EN != 0) begin
      if (rs_used) fwd_a_d = ex_hit_rs ? 2'b01 : mem_hit_rs ? 2'b10 : 2'b00;
      if (rt_used) fwd_b_d = ex_hit_rt ? 2'b01 : mem_hit_rt ? 2'b10 : 2'b00;
    end
  end

  // ---------------- EX/MEM registers + halt FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      ex_fwd_a   <= 2'b00;
      ex_fwd_b   <= 2'b00;
      mem_valid  <= 1'b0;
      mem_reg_we <= 1'b0;
      mem_wdst   <= '0;
      mem_to_reg <= 1'b0;
      state      <= RUN;
      drain_cnt  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      mem_valid  <= ex_valid_q;
      mem_reg_we <= ex_q.reg_we;
      mem_wdst   <= ex_q.wdst;
      mem_to_reg <= ex_q.mem_to_reg;
      if (issue) begin
        ex_q       <= dec;
        ex_valid_q <= 1'b1;
        ex_fwd_a   <= fwd_a_d;
        ex_fwd_b   <= fwd_b_d;
      end else begin
        // Whole bundle cleared so a bubble never looks like a load or writer.
        ex_q       <= '0;
        ex_valid_q <= 1'b0;
        ex_fwd_a   <= 2'b00;
        ex_fwd_b   <= 2'b00;
      end
      case (state)
        RUN: if (issue && is_syscall) begin
          state     <= DRAIN;
          drain_cnt <= 1'b0;
        end
        DRAIN: if (drain_cnt) begin
          state  <= HALT;
          halted <= 1'b1;
        end else begin
          drain_cnt <= 1'b1;
        end
        HALT: if (resume) begin
          state  <= RUN;
          halted <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  // MEM-stage load flag is carried for the datapath's benefit only.
  logic unused_mem_to_reg;
  assign unused_mem_to_reg = mem_to_reg;

  assign ex_valid      = ex_valid_q;
  assign ex_aluop      = ex_q.aluop;
  assign ex_reg_we     = ex_q.reg_we;
  assign ex_mem_we     = ex_q.mem_we;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_shift      = ex_q.shift;
  assign ex_shift_var  = ex_q.shift_var;
  assign ex_usign      = ex_q.usign;
  assign ex_load_imm   = ex_q.load_imm;
  assign ex_store_half = ex_q.store_half;
  assign ex_jal        = ex_q.jal;
  assign ex_branch     = ex_q.branch;
  assign ex_equ        = ex_q.equ;
  assign ex_wdst       = ex_q.wdst;
endmodule
